// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the byte/word RAM front-end controller.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_B0,
      ST_B1,
      ST_RD_LAST,
      ST_RESP,
      ST_ERR
   } state_e;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_WORD = 1'b1;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam int MEM_DEPTH_DEFAULT = 512;

endpackage

// File: rtl/mem_word_ctrl.sv
// Splits byte/word requests into little-endian byte accesses on an 8-bit RAM; 2-4 edges accept->response.
// One request in flight: req_ready low until the response handshakes; rsp_ready low stalls in RESP indefinitely.
module mem_word_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
   parameter int DATA_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic                  req_size,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*DATA_W-1:0]   rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_rw_select,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W-1:0]     mem_data_in,
   input  logic [DATA_W-1:0]     mem_data_out
);

   state_e                state_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic [2*DATA_W-1:0]   rsp_rdata_q;
   logic                  rsp_err_q;
   logic                  mem_rw_q;
   logic [ADDR_W-1:0]     mem_addr_q;
   logic [DATA_W-1:0]     mem_din_q;

   logic                  we_q;
   logic                  size_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_hi_q;

   // Last byte touched by the request, one bit wider so 0x3FF+1 cannot wrap into range.
   logic [ADDR_W:0]       last_addr;
   logic                  range_err;

   assign last_addr = {1'b0, req_addr} + {{ADDR_W{1'b0}}, req_size};
   assign range_err = (last_addr >= (ADDR_W+1)'(MEM_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_rw_q    <= RW_READ;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         we_q        <= RW_READ;
         size_q      <= SIZE_BYTE;
         addr_q      <= '0;
         wdata_hi_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  we_q        <= req_we;
                  size_q      <= req_size;
                  addr_q      <= req_addr;
                  wdata_hi_q  <= req_wdata[2*DATA_W-1:DATA_W];
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  if (range_err) begin
                     state_q <= ST_ERR;
                  end else begin
                     state_q    <= ST_B0;
                     mem_addr_q <= req_addr;
                     mem_rw_q   <= req_we;
                     mem_din_q  <= req_wdata[DATA_W-1:0];
                  end
               end
            end
            ST_B0: begin
               if (size_q == SIZE_WORD) begin
                  state_q    <= ST_B1;
                  mem_addr_q <= addr_q + ADDR_W'(1);
                  mem_din_q  <= wdata_hi_q;
               end else if (we_q == RW_WRITE) begin
                  state_q     <= ST_RESP;
                  mem_rw_q    <= RW_READ;
                  rsp_valid_q <= 1'b1;
               end else begin
                  state_q  <= ST_RD_LAST;
                  mem_rw_q <= RW_READ;
               end
            end
            ST_B1: begin
               // RAM read latency: byte 0 is on mem_data_out while byte 1 is being addressed.
               if (we_q == RW_WRITE) begin
                  state_q     <= ST_RESP;
                  mem_rw_q    <= RW_READ;
                  rsp_valid_q <= 1'b1;
               end else begin
                  state_q                  <= ST_RD_LAST;
                  mem_rw_q                 <= RW_READ;
                  rsp_rdata_q[DATA_W-1:0]  <= mem_data_out;
               end
            end
            ST_RD_LAST: begin
               if (size_q == SIZE_WORD) begin
                  rsp_rdata_q[2*DATA_W-1:DATA_W] <= mem_data_out;
               end else begin
                  rsp_rdata_q[DATA_W-1:0] <= mem_data_out;
               end
               mem_rw_q    <= RW_READ;
               state_q     <= ST_RESP;
               rsp_valid_q <= 1'b1;
            end
            ST_ERR: begin
               state_q     <= ST_RESP;
               rsp_err_q   <= 1'b1;
               rsp_valid_q <= 1'b1;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               mem_rw_q    <= RW_READ;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;
   assign mem_rw_select = mem_rw_q;
   assign mem_address   = mem_addr_q;
   assign mem_data_in   = mem_din_q;

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Directed bench for mem_word_ctrl with a behavioural 512x8 registered-read RAM.
module tb_mem_word_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_size;
   logic [9:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_rw_select;
   logic [9:0]  mem_address;
   logic [7:0]  mem_data_in;
   logic [7:0]  mem_data_out;

   logic [7:0]  ram [0:511];

   int total;
   int bad;

   typedef struct {
      logic        we;
      logic        size;
      logic [9:0]  addr;
      logic [15:0] wdata;
      int          exp_lat;
      logic [15:0] exp_rdata;
      logic        exp_err;
      logic        exp_wr;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   mem_word_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_size      (req_size),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .mem_rw_select (mem_rw_select),
      .mem_address   (mem_address),
      .mem_data_in   (mem_data_in),
      .mem_data_out  (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rw_select) ram[mem_address[8:0]] <= mem_data_in;
      mem_data_out <= ram[mem_address[8:0]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic do_req(input vec_t v, output int lat, output logic [15:0] rd,
                         output logic er, output logic wr, output logic to);
      int n;
      lat = 0; rd = '0; er = 1'b0; wr = 1'b0; to = 1'b0;
      @(negedge clk);
      req_we = v.we; req_size = v.size; req_addr = v.addr; req_wdata = v.wdata;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         to = 1'b1;
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0;
      while (!rsp_valid && lat < 20) begin
         if (mem_rw_select) wr = 1'b1;
         @(negedge clk);
         lat++;
      end
      to = !rsp_valid;
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [15:0] rd;
      logic        er, wr, to;
      int          n;
      int          e, acc_cnt, hs_cnt;
      int          acc_e [2];
      int          hs_e  [2];
      logic [15:0] got2;
      logic        acc, hs;
      vec_t        v;

      total = 0; bad = 0;
      for (int i = 0; i < 512; i++) ram[i] = 8'h00;

      //           we    size  addr     wdata    lat rdata    err   wr
      vecs[0]  = '{1'b1, 1'b0, 10'h010, 16'h00A5, 2, 16'h0000, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 10'h010, 16'h0000, 3, 16'h00A5, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 10'h101, 16'hBEEF, 3, 16'h0000, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 10'h101, 16'h0000, 4, 16'hBEEF, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 10'h102, 16'h0000, 3, 16'h00BE, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 10'h1FF, 16'h0000, 2, 16'h0000, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 10'h200, 16'h0000, 2, 16'h0000, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 10'h1FF, 16'h005A, 2, 16'h0000, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 10'h1FF, 16'h1234, 2, 16'h0000, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 10'h1FF, 16'h0000, 3, 16'h005A, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 10'h1FE, 16'h3412, 3, 16'h0000, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 10'h1FE, 16'h0000, 4, 16'h3412, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 10'h020, 16'hFF77, 2, 16'h0000, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 10'h020, 16'h0000, 4, 16'h0077, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 10'h3FF, 16'h0055, 2, 16'h0000, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 10'h3FF, 16'h0000, 2, 16'h0000, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 10'h100, 16'h0000, 4, 16'hEF00, 1'b0, 1'b0};

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_mem_rw",    32'(mem_rw_select), 32'd0);
      chk("rst_mem_addr",  32'(mem_address),   32'd0);
      chk("rst_mem_din",   32'(mem_data_in),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_req_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 chk("rel_req_ready_rise", 32'(req_ready), 32'd1);

      for (int i = 0; i < NVEC; i++) begin
         do_req(vecs[i], lat, rd, er, wr, to);
         chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
         chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d_wr", i), 32'(wr), 32'(vecs[i].exp_wr));
         if (i == 2) begin
            chk("ram_101", 32'(ram[9'h101]), 32'h00EF);
            chk("ram_102", 32'(ram[9'h102]), 32'h00BE);
         end
      end

      // Back-pressure: stall a word read of 0x1234 for 10 cycles
      v = '{1'b1, 1'b1, 10'h040, 16'h1234, 3, 16'h0000, 1'b0, 1'b1};
      do_req(v, lat, rd, er, wr, to);
      chk("bp_wr_timeout", 32'(to), 32'd0);
      @(negedge clk);
      req_we = 1'b0; req_size = 1'b1; req_addr = 10'h040; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp_rdata_c%0d", c), 32'(rsp_rdata), 32'h1234);
         chk($sformatf("bp_reqrdy_c%0d", c), 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("bp_reqrdy_back", 32'(req_ready), 32'd1);
      @(negedge clk);
      rsp_ready = 1'b0;

      // Back-to-back with req_valid held: byte write 0x11 @0x050 then byte read @0x050
      @(negedge clk);
      req_we = 1'b1; req_size = 1'b0; req_addr = 10'h050; req_wdata = 16'h0011;
      req_valid = 1'b1; rsp_ready = 1'b1;
      e = 0; acc_cnt = 0; hs_cnt = 0; got2 = '0;
      acc_e[0] = -1; acc_e[1] = -1; hs_e[0] = -1; hs_e[1] = -1;
      while (hs_cnt < 2 && e < 60) begin
         acc = req_valid && req_ready;
         hs  = rsp_valid && rsp_ready;
         if (hs) begin
            if (hs_cnt == 1) got2 = rsp_rdata;
            hs_e[hs_cnt] = e + 1;
            hs_cnt++;
         end
         @(posedge clk);
         e++;
         if (acc && acc_cnt < 2) begin
            acc_e[acc_cnt] = e;
            acc_cnt++;
            #1;
            if (acc_cnt == 1) req_we = 1'b0;
            else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0; rsp_ready = 1'b0;
      chk("b2b_hs_count", 32'(hs_cnt), 32'd2);
      chk("b2b_first_lat", 32'(hs_e[0] - acc_e[0]), 32'd2);
      chk("b2b_second_accept", 32'(acc_e[1]), 32'(hs_e[0] + 1));
      chk("b2b_second_rdata", 32'(got2), 32'h0011);

      // Reset during B1 of a word write to 0x060
      @(negedge clk);
      req_we = 1'b1; req_size = 1'b1; req_addr = 10'h060; req_wdata = 16'hCDAB;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_mem_rw",    32'(mem_rw_select), 32'd0);
      chk("mid_rst_mem_addr",  32'(mem_address),   32'd0);
      chk("mid_rst_mem_din",   32'(mem_data_in),   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mid_rel_req_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
      chk("mid_rel_no_rsp", 32'(rsp_valid), 32'd0);
      chk("mid_ram_060", 32'(ram[9'h060]), 32'h00AB);
      chk("mid_ram_061", 32'(ram[9'h061]), 32'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_word_ctrl.md
Name: mem_word_ctrl

Overview:
- Front-end controller sitting directly upstream of the team's 8-bit single-port RAM (512 bytes, 10-bit address, rw_select 1=write, registered read with 1-cycle latency).
- Accepts byte or 16-bit word requests over a valid/ready handshake.
- Splits each word into two sequential byte accesses (little-endian), captures read bytes on the RAM's latency, and returns one response per request.
- Range-checks addresses so that out-of-range requests never reach the RAM.

Parameters:
- ADDR_W, 10, byte-address width on the request side and the RAM side.
- MEM_DEPTH, 512, number of valid RAM bytes; valid addresses are 0..MEM_DEPTH-1.
- DATA_W, 8, RAM byte width; word width is 2*DATA_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_size  in  1  0=byte, 1=word.
- req_addr  in  ADDR_W  byte address; a word uses addr and addr+1.
- req_wdata  in  2*DATA_W  write data; byte writes use [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  2*DATA_W  read data; zero for writes and errors.
- rsp_err  out  1  request was out of range; no RAM access was made.
- mem_rw_select  out  1  to RAM rw_select.
- mem_address  out  ADDR_W  to RAM address.
- mem_data_in  out  DATA_W  to RAM data_in.
- mem_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset values (async, on rst_n low):
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_rw_select=0, mem_address=0, mem_data_in=0.
  - req_ready rises on the first clk edge after rst_n deasserts.
- All outputs are registered.
- States: IDLE, B0, B1, RD_LAST, RESP, ERR.
- IDLE:
  - req_ready=1.
  - Accept occurs on an edge with req_valid&req_ready; the command is latched and req_ready drops.
  - If addr>=MEM_DEPTH, or size=word and addr==MEM_DEPTH-1 (no wrap), go to ERR.
  - Otherwise go to B0, driving mem_address=addr, mem_rw_select=we, mem_data_in=wdata[7:0].
- B0:
  - RAM performs byte 0 at the end edge.
  - Next state is B1 (word), RD_LAST (byte read), or RESP (byte write).
  - Entering B1 drives addr+1 and wdata[15:8], with rw_select held at we.
- B1:
  - RAM performs byte 1.
  - For reads, mem_data_out (byte 0 result) is captured into rdata[7:0] at this edge.
  - Next state is RESP (write) or RD_LAST (read).
- RD_LAST:
  - Captures mem_data_out into rdata[7:0] (byte read) or rdata[15:8] (word read).
  - mem_rw_select=0, address held.
  - Next state is RESP.
- ERR: one cycle, no RAM access, then RESP with rsp_err=1 and rdata=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable until rsp_valid&rsp_ready.
  - On that edge: rsp_valid=0, go to IDLE, req_ready=1.
- Write-enable rule: mem_rw_select=1 only in B0/B1 of a write; 0 in every other state, including reset.
- Byte read: rdata[15:8]=0.
- Latency (edges from accept to rsp_valid high): byte write 2, word write 3, byte read 3, word read 4, error 2.
- Back-pressure: a held-off rsp_ready stalls in RESP indefinitely; the RAM sees reads only.
- Only one request is outstanding; req_ready=0 from accept until response acceptance.
- Misaligned words (odd addr) are legal.
- Reset mid-operation: the transaction is abandoned with no response. A word write interrupted after B0 leaves byte 0 written; the RAM itself is not reset.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state enum;
  - size encoding constants SIZE_BYTE=0, SIZE_WORD=1;
  - RW_READ=0, RW_WRITE=1;
  - MEM_DEPTH default.
- Single module; no sub-module. The range check is one comparison inline.

Test Plan:
- Byte write 0xA5 to addr 0x010, then byte read 0x010 -> write rsp_valid 2 edges after accept with rdata=0, err=0; read rsp_rdata=0x00A5 3 edges after accept.
- Word write 0xBEEF to addr 0x101, then word read 0x101 -> RAM[0x101]=0xEF, RAM[0x102]=0xBE; read returns 0xBEEF after 4 edges; mem_rw_select never 1 during the read.
- Word read at 0x1FF, and byte read at 0x200 -> rsp_err=1, rdata=0, mem_rw_select stays 0, 2 edges after accept.
- Hold rsp_ready=0 for 10 cycles after a read of 0x1234 -> rsp_valid and rsp_rdata stable; req_ready=0 throughout; accepted on the first rsp_ready cycle; req_ready=1 the next cycle.
- Back-to-back requests with req_valid held high -> second accept occurs exactly 1 edge after the first response handshake.
- Assert rst_n low during B1 of a word write -> all outputs reset immediately (async), no response issued; req_ready=1 one edge after release.
